// File: rtl/posit_pkg.sv
// posit_pkg
// Shared constants for the posit datapath: the normaliser, the encoder and
// the decoder all derive their widths from the same WIDTH/EXP pair.
// The pattern functions return a 64-bit word; callers take the low
// WIDTH bits they need.
package posit_pkg;

    localparam int POSIT_WIDTH = 8;
    localparam int POSIT_EXP   = 2;
    localparam int POSIT_MTS   = POSIT_WIDTH - 3 - POSIT_EXP;
    localparam int POSIT_REGI  = $clog2(POSIT_WIDTH) + 1;
    localparam int POSIT_SFW   = POSIT_REGI + POSIT_EXP + 1;
    localparam int POSIT_MW    = 2 * (POSIT_MTS + 1);
    localparam int POSIT_MAXSF = (POSIT_WIDTH - 2) * (2 ** POSIT_EXP);

    // Largest positive posit: 0 followed by w-1 ones.
    function automatic logic [63:0] posit_maxpos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Smallest positive posit: w-1 zeros then a 1.
    function automatic logic [63:0] posit_minpos(input int w);
        return 64'd1;
    endfunction

    // Not-a-Real: 1 followed by w-1 zeros.
    function automatic logic [63:0] posit_nar(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/posit_rne.sv
// posit_rne
// Round-to-nearest-even on a posit body (everything below the sign bit).
// Purely combinational.
//   body    : truncated body bits
//   guard   : first dropped bit
//   sticky  : OR of all further dropped bits
//   rounded : rounded body, clamped at maxpos so no carry reaches the sign
module posit_rne
    import posit_pkg::*;
#(
    parameter int BW = POSIT_WIDTH - 1
) (
    input  logic [BW-1:0] body,
    input  logic          guard,
    input  logic          sticky,
    output logic [BW-1:0] rounded
);

    logic inc;
    logic at_max;

    assign inc    = guard & (sticky | body[0]);
    // An all-ones body is maxpos; incrementing it would wrap into NaR.
    assign at_max = &body;

    always_comb begin
        rounded = body;
        if (inc && !at_max) begin
            rounded = body + BW'(1);
        end
    end

endmodule

// File: rtl/posit_sf_enc.sv
// posit_sf_enc
// Three-stage pipelined posit encoder. Takes the normalised
// (sign, scale factor, 1.f mantissa) triple and produces a WIDTH-bit posit
// with EXP exponent bits, rounding to nearest even and saturating to
// +-maxpos / +-minpos.
// Ports:
//   clk_i, rstn       : clock, asynchronous active-low reset
//   vld_i / rdy_o     : input handshake
//   sign_i, zero_i,
//   nar_i, sf_i, mts_i: input triple and special-value flags
//   vld_o / rdy_i     : output handshake
//   posit_o           : encoded posit
// One global enable freezes every stage while the sink stalls.
module posit_sf_enc
    import posit_pkg::*;
#(
    parameter int WIDTH = POSIT_WIDTH,
    parameter int EXP   = POSIT_EXP,
    parameter int MTS   = WIDTH - 3 - EXP,
    parameter int REGI  = $clog2(WIDTH) + 1,
    parameter int SFW   = REGI + EXP + 1,
    parameter int MW    = 2 * (MTS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn,
    input  logic                  vld_i,
    output logic                  rdy_o,
    input  logic                  sign_i,
    input  logic                  zero_i,
    input  logic                  nar_i,
    input  logic signed [SFW-1:0] sf_i,
    input  logic        [MW-1:0]  mts_i,
    output logic                  vld_o,
    input  logic                  rdy_i,
    output logic        [WIDTH-1:0] posit_o
);

    localparam int MAXSF = (WIDTH - 2) * (2 ** EXP);
    localparam int BW    = WIDTH - 1;         // body bits below the sign
    localparam int SH    = WIDTH + MW;        // shifter width
    localparam int SEEDW = MW + EXP + 1;      // {2 regime seed bits, e, f}
    localparam int PAD   = SH - SEEDW;
    localparam int KW    = SFW - EXP;         // regime count k width

    localparam logic signed [SFW-1:0] SF_MAX = SFW'(MAXSF);
    localparam logic signed [SFW-1:0] SF_MIN = SFW'(-MAXSF);

    localparam logic [63:0] MAXPOS64 = posit_maxpos(WIDTH);
    localparam logic [63:0] MINPOS64 = posit_minpos(WIDTH);
    localparam logic [63:0] NAR64    = posit_nar(WIDTH);

    logic en;

    assign en    = ~vld_o | rdy_i;
    assign rdy_o = en;

    // ------------------------------------------------------------------
    // S1: capture inputs, split sf into k and e, flag saturation/specials
    // ------------------------------------------------------------------
    logic                 s1_vld_reg;
    logic                 s1_sign_reg;
    logic                 s1_nar_reg;
    logic                 s1_zero_reg;
    logic                 s1_max_reg;
    logic                 s1_min_reg;
    logic signed [KW-1:0] s1_k_reg;
    logic [EXP-1:0]       s1_e_reg;
    logic [MW-2:0]        s1_frac_reg;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s1_vld_reg  <= 1'b0;
            s1_sign_reg <= 1'b0;
            s1_nar_reg  <= 1'b0;
            s1_zero_reg <= 1'b0;
            s1_max_reg  <= 1'b0;
            s1_min_reg  <= 1'b0;
            s1_k_reg    <= '0;
            s1_e_reg    <= '0;
            s1_frac_reg <= '0;
        end else if (en) begin
            s1_vld_reg  <= vld_i;
            s1_sign_reg <= sign_i;
            s1_nar_reg  <= nar_i;
            s1_zero_reg <= zero_i & ~nar_i;
            s1_max_reg  <= (sf_i >= SF_MAX);
            s1_min_reg  <= (sf_i < SF_MIN);
            // Dropping the low EXP bits of a two's-complement value is
            // exactly the flooring arithmetic shift.
            s1_k_reg    <= sf_i[SFW-1:EXP];
            s1_e_reg    <= sf_i[EXP-1:0];
            s1_frac_reg <= mts_i[MW-2:0];
        end
    end

    // ------------------------------------------------------------------
    // S2: build {regime, e, f} with one arithmetic shift
    // ------------------------------------------------------------------
    // Seed is 10 (k>=0) or 01 (k<0) followed by e and f. Shifting right
    // arithmetically by k (k>=0) replicates the leading 1 into k+1 ones
    // then a 0; by -k-1 (k<0) replicates the leading 0 into -k zeros then
    // a 1. For k<0, -k-1 is just ~k.
    logic                 k_neg;
    logic [KW-1:0]        shamt;
    logic signed [SH-1:0] seed;
    logic signed [SH-1:0] shifted;
    logic [BW-1:0]        body_next;
    logic                 guard_next;
    logic                 sticky_next;

    assign k_neg   = s1_k_reg[KW-1];
    assign shamt   = k_neg ? ~s1_k_reg : s1_k_reg;
    assign seed    = {~k_neg, k_neg, s1_e_reg, s1_frac_reg, {PAD{1'b0}}};
    assign shifted = seed >>> shamt;

    always_comb begin
        body_next   = shifted[SH-1 -: BW];
        guard_next  = shifted[SH-WIDTH];
        sticky_next = |shifted[SH-WIDTH-1:0];
        if (s1_max_reg) begin
            body_next   = MAXPOS64[BW-1:0];
            guard_next  = 1'b0;
            sticky_next = 1'b0;
        end else if (s1_min_reg) begin
            body_next   = MINPOS64[BW-1:0];
            guard_next  = 1'b0;
            sticky_next = 1'b0;
        end
    end

    logic          s2_vld_reg;
    logic          s2_sign_reg;
    logic          s2_nar_reg;
    logic          s2_zero_reg;
    logic [BW-1:0] s2_body_reg;
    logic          s2_guard_reg;
    logic          s2_sticky_reg;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s2_vld_reg    <= 1'b0;
            s2_sign_reg   <= 1'b0;
            s2_nar_reg    <= 1'b0;
            s2_zero_reg   <= 1'b0;
            s2_body_reg   <= '0;
            s2_guard_reg  <= 1'b0;
            s2_sticky_reg <= 1'b0;
        end else if (en) begin
            s2_vld_reg    <= s1_vld_reg;
            s2_sign_reg   <= s1_sign_reg;
            s2_nar_reg    <= s1_nar_reg;
            s2_zero_reg   <= s1_zero_reg;
            s2_body_reg   <= body_next;
            s2_guard_reg  <= guard_next;
            s2_sticky_reg <= sticky_next;
        end
    end

    // ------------------------------------------------------------------
    // S3: round, apply sign, select specials
    // ------------------------------------------------------------------
    logic [BW-1:0]    rnd_body;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] posit_next;

    posit_rne #(
        .BW(BW)
    ) u_rne (
        .body    (s2_body_reg),
        .guard   (s2_guard_reg),
        .sticky  (s2_sticky_reg),
        .rounded (rnd_body)
    );

    assign mag = {1'b0, rnd_body};

    always_comb begin
        posit_next = mag;
        if (s2_nar_reg) begin
            posit_next = NAR64[WIDTH-1:0];
        end else if (s2_zero_reg) begin
            posit_next = '0;
        end else if (s2_sign_reg) begin
            posit_next = ~mag + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            vld_o   <= 1'b0;
            posit_o <= '0;
        end else if (en) begin
            vld_o <= s2_vld_reg;
            if (s2_vld_reg) begin
                posit_o <= posit_next;
            end
        end
    end

endmodule

// File: doc/posit_sf_enc.md
# posit_sf_enc

Pipelined posit encoder: converts a normalised (sign, scale factor, mantissa) triple into a WIDTH-bit posit with EXP exponent bits. Round-to-nearest-even, saturating to ±maxpos/±minpos. Sits directly after the accumulator normaliser, which produces the sign / scale-factor / 1.f-mantissa triple, and writes the final posit result of the dot-product datapath. Carries a valid/ready handshake so it can stall against the result sink.

## Interface
- WIDTH, 8: posit word width.
- EXP, 2: posit exponent field width (es).
- MTS, WIDTH-3-EXP: maximum posit fraction bits.
- REGI, $clog2(WIDTH)+1: regime-count width.
- SFW, REGI+EXP+1: scale-factor width (signed).
- MW, 2*(MTS+1): mantissa input width, 1.f format with the MSB as the integer bit.

Ports (clock and reset first):
- clk_i  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- vld_i  in  1  input triple valid.
- rdy_o  out  1  encoder can accept input.
- sign_i  in  1  sign of the value.
- zero_i  in  1  value is exactly zero; overrides sf_i and mts_i.
- nar_i  in  1  value is NaR; overrides everything else.
- sf_i  in  SFW  signed scale factor; value = (-1)^sign × 2^sf × mts.
- mts_i  in  MW  mantissa; mts_i[MW-1] = 1 when not zero.
- vld_o  out  1  posit_o valid.
- rdy_i  in  1  sink accepts posit_o.
- posit_o  out  WIDTH  encoded posit.

## Operation
- **k/e split:** k = sf_i >>> EXP (arithmetic, floor). e = sf_i[EXP-1:0].
- **Saturation:**
  - MAXSF = (WIDTH-2)·2^EXP.
  - sf_i ≥ MAXSF → magnitude maxpos (0 followed by WIDTH-1 ones).
  - sf_i < -MAXSF → magnitude minpos (WIDTH-1 zeros, then a 1).
  - Posits never round to zero or to NaR.
- **Regime bits:**
  - k ≥ 0: k+1 ones, then a 0.
  - k < 0: -k zeros, then a 1.
  - Regime length r = (k ≥ 0 ? k+2 : -k+1).
- **Bit string:** form {regime, e, mts_i[MW-2:0]}. Truncate to WIDTH-1 body bits.
  - guard = first dropped bit.
  - sticky = OR of the remaining dropped bits.
- **Rounding (RNE):** increment the body when guard & (sticky | body LSB).
  - Clamp the rounded body to maxpos, i.e. no carry into the sign bit.
  - An unsaturated nonzero body never rounds below minpos.
- **Sign:** posit_o = sign_i ? two's complement of {0, body} : {0, body}.
- **Special inputs:**
  - zero_i → 0.
  - nar_i → 1 followed by WIDTH-1 zeros.
  - nar_i has priority over zero_i.
- **Datapath width:** the widest intermediate is a shifter of WIDTH+MW bits; do not build anything wider.

## Timing
- **Pipeline:** 3 register stages, latency exactly 3 cycles from accepted input to vld_o.
  - S1: register inputs; compute k, e, saturation and special flags.
  - S2: regime/exponent/fraction shift; extract guard and sticky.
  - S3: rounding, clamp, sign negation into the posit_o register.
- **Handshake:**
  - Global enable en = ~vld_o | rdy_i. rdy_o = en.
  - A transfer occurs on vld_i & rdy_o, and on vld_o & rdy_i.
  - A stall freezes all stages; posit_o and vld_o hold stable while vld_o & ~rdy_i.
- **Throughput:** one result per cycle when rdy_i is held high.
- **Bubbles:** vld is tracked per stage. Bubbles flow through; they are not compressed while en = 1.
- **Reset:** all stage valids = 0, vld_o = 0, posit_o = 0. rdy_o = 1 after reset.
- **Reset mid-operation:** in-flight results are discarded; no spurious vld_o after rstn deasserts.
- **Simultaneous accept and drain:** in the same cycle, both transfers occur; no loss, no duplication.

## Structure
- **Package posit_pkg:** holds the derived localparams (MTS, REGI, SFW, MW, MAXSF), plus function constants for the maxpos/minpos/NaR patterns. It is shared with the normaliser and decoder blocks.
- **Sub-module posit_rne:** combinational; takes body, guard and sticky and returns the rounded, clamped body. S3 instantiates it.
- Everything else is inline in posit_sf_enc.

## Test plan
All values use WIDTH=8, EXP=2, rdy_i=1 unless stated.
- **Basic encodes:**
  - sf=0, mts=8'h80 → 8'h40, 3 cycles after acceptance.
  - sf=0, mts=8'hC0 → 8'h44.
  - sf=5, mts=8'h80 → 8'h64.
  - sign=1, sf=0, mts=8'h80 → 8'hC0.
- **Rounding:**
  - sf=0, mts=8'h88 (tie, LSB 0) → 8'h40.
  - sf=0, mts=8'h98 (tie, LSB 1) → 8'h42.
  - sf=0, mts=8'h8C (above tie) → 8'h41.
- **Saturation:**
  - sf=30 → 8'h7F.
  - sf=-30 → 8'h01.
  - sign=1, sf=30 → 8'h81.
  - sf=23, mts=8'hFF (rounding carry) → 8'h7F, not NaR.
- **Specials:**
  - zero_i=1 with any sf/mts → 8'h00.
  - nar_i=1 → 8'h80.
  - nar_i and zero_i both high → 8'h80.
- **Backpressure:** stream 6 values back-to-back; hold rdy_i=0 for 4 cycles mid-stream.
  - posit_o stays stable and rdy_o=0 during the stall.
  - All 6 results arrive in order with no drop or duplicate.
- **Reset:** assert rstn low with 2 results in flight.
  - vld_o=0 and posit_o=0 immediately.
  - No output appears after release until new inputs arrive.
